uart_rx_fifo: RTL and testbench

// - Serial receive front end for the SoC console UART: takes the raw ui_in[3] pin and hands

---
 rtl/uart_rx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver for the console pin with a small first-word fall-through receive FIFO.
// Provides a 2-flop synchronizer, mid-bit sampling, false-start rejection, and overrun and framing-error pulses.
module uart_rx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] divisor,
    input  logic             rd_en,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_full,
    output logic             overrun,
    output logic             frame_err,
    output logic             rx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [1:0]       state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       bit_r;
    logic [7:0]       shift_r;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    logic             stop_tick_s;
    logic             push_s;
    logic             ferr_s;
    logic             full_s;
    logic             pop_s;
    logic             wr_s;
    logic             ovr_s;

    // Stop-bit verdict; a low stop bit drops the byte and flags it.
    assign stop_tick_s = (state_r == ST_STOP) && (cnt_r == DIV_ZERO);
    assign push_s      = stop_tick_s && rx_sync_r;
    assign ferr_s      = stop_tick_s && !rx_sync_r;

    // When full, a push is only accepted if a pop frees a slot in the same cycle.
    assign full_s = (count_r == DEPTH_C);
    assign pop_s  = rd_en && (count_r != {(AW+1){1'b0}});
    assign wr_s   = push_s && (!full_s || pop_s);
    assign ovr_s  = push_s && full_s && !pop_s;

    assign rx_data  = mem_r[rd_ptr_r];
    assign rx_valid = (count_r != {(AW+1){1'b0}});
    assign rx_full  = full_s;
    assign rx_busy  = (state_r != ST_IDLE);

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM; the divisor is captured at the start edge and held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= DIV_ZERO;
            div_r   <= DIV_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        div_r   <= divisor;
                        cnt_r   <= divisor >> 1;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_r != DIV_ZERO) begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end else if (!rx_sync_r) begin
                        cnt_r   <= div_r - DIV_ONE;
                        bit_r   <= 3'd0;
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r != DIV_ZERO) begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end else begin
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        cnt_r   <= div_r - DIV_ONE;
                        if (bit_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_r != DIV_ZERO) begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_s;
            frame_err <= ferr_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames
// checked against a queue model of the receive FIFO.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic [15:0] divisor;
    logic        rd_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic        overrun;
    logic        frame_err;
    logic        rx_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] model_q[$];
    int rise_t;
    int fe_seen;
    int ov_seen;
    int both_seen;
    int lat_d4;

    uart_rx_fifo #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .divisor(divisor), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .overrun(overrun), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Serial frame driver; observes flags every cycle, 1 time unit after the edge.
    task automatic send_frame(input logic [7:0] b, input int d, input logic stop_ok, input int pop_at);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        rise_t = -1; fe_seen = 0; ov_seen = 0; both_seen = 0;
        for (int t = 0; t < 11*d + 10; t++) begin
            rx_i    = (t < 10*d) ? bits[t/d] : 1'b1;
            divisor = (t > 5) ? 16'($urandom_range(4, 60)) : 16'(d);
            rd_en   = (t == pop_at);
            @(posedge clk); #1;
            if (rx_valid === 1'b1 && rise_t < 0) rise_t = t + 1;
            if (frame_err === 1'b1) fe_seen++;
            if (overrun === 1'b1) ov_seen++;
            if (frame_err === 1'b1 && overrun === 1'b1) both_seen++;
        end
        rd_en = 1'b0;
        rx_i  = 1'b1;
    endtask

    task automatic pop_head();
        logic [7:0] exp;
        exp = model_q.pop_front();
        total_cnt++;
        if (rx_valid !== 1'b1) $display("FAIL pop_valid: got %b want 1", rx_valid);
        else pass_cnt++;
        total_cnt++;
        if (rx_data !== exp) $display("FAIL pop_data: got %h want %h", rx_data, exp);
        else pass_cnt++;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    // Returns expected overrun count for one good frame with no concurrent pop.
    function automatic int model_push(input logic [7:0] b);
        if (model_q.size() == 8) return 1;
        model_q.push_back(b);
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_i = 1'b1; rd_en = 1'b0; divisor = 16'd8;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_full !== 1'b0) $display("FAIL reset_full: got %b want 0", rx_full); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++; if (rx_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", rx_busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        int mid;
        mid = 9*8 + 4;
        void'(model_push(8'hA5));
        send_frame(8'hA5, 8, 1'b1, -1);
        total_cnt++;
        if (rise_t < mid || rise_t > mid + 5) $display("FAIL basic_latency: got %0d want %0d..%0d", rise_t, mid, mid + 5);
        else pass_cnt++;
        total_cnt++; if (fe_seen + ov_seen != 0) $display("FAIL basic_flags: got %0d want 0", fe_seen + ov_seen); else pass_cnt++;
        pop_head();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_empty: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_false_start();
        int busy_seen = 0;
        int valid_seen = 0;
        int flag_seen = 0;
        divisor = 16'd16;
        for (int t = 0; t < 40; t++) begin
            rx_i = (t < 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (rx_busy === 1'b1) busy_seen++;
            if (rx_valid === 1'b1) valid_seen++;
            if (frame_err === 1'b1 || overrun === 1'b1) flag_seen++;
        end
        total_cnt++; if (busy_seen == 0) $display("FAIL glitch_busy_seen: got %0d want >0", busy_seen); else pass_cnt++;
        total_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle: got %b want 0", rx_busy); else pass_cnt++;
        total_cnt++; if (valid_seen != 0) $display("FAIL glitch_valid: got %0d want 0", valid_seen); else pass_cnt++;
        total_cnt++; if (flag_seen != 0) $display("FAIL glitch_flags: got %0d want 0", flag_seen); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 8, 1'b0, -1);
        total_cnt++; if (fe_seen != 1) $display("FAIL ferr_pulse: got %0d cycles want 1", fe_seen); else pass_cnt++;
        total_cnt++; if (ov_seen != 0) $display("FAIL ferr_ovr: got %0d want 0", ov_seen); else pass_cnt++;
        total_cnt++; if (rise_t != -1) $display("FAIL ferr_valid: rose at %0d want never", rise_t); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int exp_ov;
        for (int i = 0; i < 9; i++) begin
            exp_ov = model_push(8'(i));
            send_frame(8'(i), 4, 1'b1, -1);
            if (i == 0) lat_d4 = rise_t;
            total_cnt++;
            if (ov_seen != exp_ov) $display("FAIL ovr_byte%0d: got %0d want %0d", i, ov_seen, exp_ov);
            else pass_cnt++;
            total_cnt++;
            if (rx_full !== (i >= 7)) $display("FAIL ovr_full%0d: got %b want %b", i, rx_full, (i >= 7));
            else pass_cnt++;
        end
        total_cnt++;
        if (lat_d4 < 38 || lat_d4 > 43) $display("FAIL d4_latency: got %0d want 38..43", lat_d4);
        else pass_cnt++;
        while (model_q.size() > 0) pop_head();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            void'(model_push(b));
            send_frame(b, 4, 1'b1, -1);
        end
        total_cnt++; if (rx_full !== 1'b1) $display("FAIL pp_full_before: got %b want 1", rx_full); else pass_cnt++;
        total_cnt++;
        if (rx_data !== model_q[0]) $display("FAIL pp_head: got %h want %h", rx_data, model_q[0]);
        else pass_cnt++;
        b = 8'($urandom);
        void'(model_q.pop_front());
        model_q.push_back(b);
        send_frame(b, 4, 1'b1, lat_d4 - 1);
        total_cnt++; if (ov_seen != 0) $display("FAIL pp_overrun: got %0d want 0", ov_seen); else pass_cnt++;
        total_cnt++; if (rx_full !== 1'b1) $display("FAIL pp_full_after: got %b want 1", rx_full); else pass_cnt++;
        while (model_q.size() > 0) pop_head();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL pp_drained: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int bad = 0;
        void'(model_push(8'h11));
        send_frame(8'h11, 8, 1'b1, -1);
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL rm_preload: got %b want 1", rx_valid); else pass_cnt++;
        bits = {1'b1, 8'h96, 1'b0};
        divisor = 16'd8;
        for (int t = 0; t < 4*8 + 4; t++) begin
            rx_i = bits[t/8];
            @(posedge clk); #1;
        end
        total_cnt++; if (rx_busy !== 1'b1) $display("FAIL rm_busy: got %b want 1", rx_busy); else pass_cnt++;
        rst = 1'b1; rx_i = 1'b1;
        #1;
        total_cnt++;
        if ({rx_data, rx_valid, rx_full, overrun, frame_err, rx_busy} !== 13'h0)
            $display("FAIL rm_outputs: got %h/%b%b%b%b%b want 00/00000", rx_data, rx_valid, rx_full, overrun, frame_err, rx_busy);
        else pass_cnt++;
        model_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (rx_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL rm_quiet: got %0d bad cycles want 0", bad); else pass_cnt++;
        void'(model_push(8'h5A));
        send_frame(8'h5A, 8, 1'b1, -1);
        total_cnt++; if (fe_seen + ov_seen != 0) $display("FAIL rm_flags: got %0d want 0", fe_seen + ov_seen); else pass_cnt++;
        pop_head();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rm_empty: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        int d;
        int exp_ov;
        logic [7:0] b;
        logic ok;
        for (int i = 0; i < 30; i++) begin
            d  = $urandom_range(4, 20);
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            exp_ov = ok ? model_push(b) : 0;
            send_frame(b, d, ok, -1);
            total_cnt++;
            if (fe_seen != (ok ? 0 : 1)) $display("FAIL rnd_ferr%0d: got %0d want %0d", i, fe_seen, ok ? 0 : 1);
            else pass_cnt++;
            total_cnt++;
            if (ov_seen != exp_ov) $display("FAIL rnd_ovr%0d: got %0d want %0d", i, ov_seen, exp_ov);
            else pass_cnt++;
            total_cnt++;
            if (both_seen != 0) $display("FAIL rnd_both%0d: got %0d want 0", i, both_seen);
            else pass_cnt++;
            total_cnt++;
            if (rx_full !== (model_q.size() == 8)) $display("FAIL rnd_full%0d: got %b want %b", i, rx_full, (model_q.size() == 8));
            else pass_cnt++;
            if ($urandom_range(0, 2) == 0 && model_q.size() > 0) pop_head();
        end
        while (model_q.size() > 0) pop_head();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rnd_drained: got %b want 0", rx_valid); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; rx_i = 1'b1; rd_en = 1'b0; divisor = 16'd8;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
